isa_movx: RTL
=============

Name: isa_movx

Overview:
- Parametrised register-move executor for the CPU's ISA execution stage; successor to the single-mode register move unit.
- Supports four modes: register move, load-immediate, move-if-nonzero, and register exchange.
- Talks to the register file over the shared single-port read/write interface.
- Uses the enabled/finished handshake with the instruction sequencer.

Parameters:
WIDTH, 64, register data width in bits
REG_BITS, 4, register index width (2**REG_BITS registers)

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  asynchronous active-high reset
enabled  in  1  sequencer request; held high for the whole instruction
mode  in  2  operation select: 0 MOV, 1 LDI, 2 MOVNZ, 3 XCHG
r0  in  REG_BITS  source register (MOV/MOVNZ), first register (XCHG)
r1  in  REG_BITS  destination register (MOV/LDI/MOVNZ), second register (XCHG)
imm  in  WIDTH  immediate for LDI
reg_out  in  WIDTH  register file read data
reg_id  out  REG_BITS  register file index
reg_re  out  1  register file read enable
reg_wd  out  WIDTH  register file write data
reg_we  out  1  register file write enable, one-cycle pulse per write
finished  out  1  instruction complete
skipped  out  1  MOVNZ suppressed its write; valid while finished=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
  - Reset values: reg_id=0, reg_re=0, reg_wd=0, reg_we=0, finished=0, skipped=0, state=IDLE, temporaries=0.
- Register file contract: read is combinational. reg_out = regs[reg_id] in the same cycle reg_re=1. The block samples reg_out at the posedge ending that cycle. The write occurs at the posedge where reg_we=1.
- Start: at a posedge in IDLE with enabled=1, the block latches mode, r0, r1 and imm. Later changes to these inputs are ignored until the next start. Call this posedge E0.
- States: IDLE, RD0, RD1, WR1, WR0, DONE.
- MOV:
  - E0: reg_id=r0, reg_re=1, go to RD0.
  - E1: tmp0=reg_out; reg_re=0; reg_id=r1, reg_wd=reg_out, reg_we=1; go to WR1.
  - E2: reg_we=0, finished=1, go to DONE.
- LDI:
  - E0: reg_id=r1, reg_wd=imm, reg_we=1, go to WR1.
  - E1: reg_we=0, finished=1, go to DONE. No read is issued.
- MOVNZ: same as MOV, except at E1 if reg_out==0:
  - reg_re=0; no write pulse.
  - finished=1, skipped=1, go to DONE.
- XCHG:
  - E0: read r0, go to RD0.
  - E1: tmp0=reg_out; reg_id=r1, reg_re=1; go to RD1.
  - E2: tmp1=reg_out; reg_re=0; write r1<=tmp0 (reg_we=1); go to WR1.
  - E3: reg_id=r0, reg_wd=tmp1, reg_we=1; go to WR0.
  - E4: reg_we=0, finished=1, go to DONE.
  - r0==r1 is legal: the register value is unchanged, using the same five-edge sequence.
- reg_re and reg_we are never high in the same cycle. reg_we is never high for two consecutive cycles except E2–E3 of XCHG, where the two pulses go to different indices (same index when r0==r1).
- DONE: finished (and skipped, if set) hold while enabled=1. At the first posedge with enabled=0, clear finished and skipped and return to IDLE. A new instruction needs enabled low for at least one posedge.
- Abort: enabled=0 at any posedge in a non-IDLE, non-DONE state:
  - Clear reg_re, reg_we, finished, skipped; go to IDLE.
  - A write already pulsed stays committed; no further writes occur.
- Reset mid-operation: immediate return to reset values; any pending write is dropped.
- Widths: data paths are exactly WIDTH bits with no extension. The MOVNZ zero test covers all WIDTH bits.

Decomposition:
- Shared package isa_pkg holds:
  - the mode encodings ISA_MOV=0, ISA_LDI=1, ISA_MOVNZ=2, ISA_XCHG=3;
  - the state encodings, 3 bits.
- No sub-module: a single FSM with two WIDTH-bit temporaries.

Test Plan:
- MOV: regs[3]=64'hDEAD_BEEF_0000_0001, r0=3, r1=7 -> reg_re at E0 with id 3; one reg_we pulse at E1 with id 7 and that data; finished after E2; regs[7] matches.
- LDI: imm=64'h0123_4567_89AB_CDEF, r1=2 -> no reg_re ever; reg_we at E0 with id 2; finished after E1; regs[2]=imm.
- MOVNZ: regs[5]=0, r0=5, r1=6 -> no reg_we, finished and skipped after E1, regs[6] unchanged. Repeat with regs[5]=9 -> regs[6]=9, skipped=0.
- XCHG: regs[1]=11, regs[4]=44, r0=1, r1=4 -> two reads then two consecutive write pulses (id 4 data 11, then id 1 data 44); finished after E4; regs[1]=44, regs[4]=11.
- Abort and handshake: drop enabled after E2 of XCHG -> next posedge reg_we=0, finished=0, IDLE; regs[4]=11, regs[1] unchanged. Hold enabled in DONE for 5 cycles -> finished stays 1; lower it -> cleared next posedge.
- Reset: assert rst asynchronously mid-MOV (between clock edges) -> all outputs 0 immediately, no write. Check WIDTH=32, REG_BITS=5 instance for MOV to r31.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared encodings for the ISA register-move executor: operation modes and FSM states.
package isa_pkg;

    typedef enum logic [1:0] {
        ISA_MOV   = 2'd0,
        ISA_LDI   = 2'd1,
        ISA_MOVNZ = 2'd2,
        ISA_XCHG  = 2'd3
    } isa_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR1  = 3'd3,
        ST_WR0  = 3'd4,
        ST_DONE = 3'd5
    } isa_state_e;

endpackage

// File: rtl/isa_movx.sv
// Register-move executor: MOV / LDI / MOVNZ / XCHG over a single-port register file,
// driven by the sequencer's enabled/finished handshake.
module isa_movx
    import isa_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enabled,
    input  logic [1:0]          mode,
    input  logic [REG_BITS-1:0] r0,
    input  logic [REG_BITS-1:0] r1,
    input  logic [WIDTH-1:0]    imm,
    input  logic [WIDTH-1:0]    reg_out,
    output logic [REG_BITS-1:0] reg_id,
    output logic                reg_re,
    output logic [WIDTH-1:0]    reg_wd,
    output logic                reg_we,
    output logic                finished,
    output logic                skipped,
    output isa_state_e          state_dbg
);

    // Handshake: enabled rises to request an instruction and stays high until finished
    // has been seen; dropping it mid-instruction aborts, dropping it in DONE retires.
    isa_state_e          state_q, state_d;
    isa_mode_e           mode_q, mode_d;
    logic [REG_BITS-1:0] r0_q, r0_d, r1_q, r1_d;
    logic [WIDTH-1:0]    tmp0_q, tmp0_d, tmp1_q, tmp1_d;
    logic [REG_BITS-1:0] reg_id_q, reg_id_d;
    logic                reg_re_q, reg_re_d;
    logic [WIDTH-1:0]    reg_wd_q, reg_wd_d;
    logic                reg_we_q, reg_we_d;
    logic                fin_q, fin_d;
    logic                skip_q, skip_d;
    logic                busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= ISA_MOV;
            r0_q     <= '0;
            r1_q     <= '0;
            tmp0_q   <= '0;
            tmp1_q   <= '0;
            reg_id_q <= '0;
            reg_re_q <= 1'b0;
            reg_wd_q <= '0;
            reg_we_q <= 1'b0;
            fin_q    <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            tmp0_q   <= tmp0_d;
            tmp1_q   <= tmp1_d;
            reg_id_q <= reg_id_d;
            reg_re_q <= reg_re_d;
            reg_wd_q <= reg_wd_d;
            reg_we_q <= reg_we_d;
            fin_q    <= fin_d;
            skip_q   <= skip_d;
        end
    end

    assign busy = (state_q == ST_RD0) || (state_q == ST_RD1) ||
                  (state_q == ST_WR1) || (state_q == ST_WR0);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        tmp0_d   = tmp0_q;
        tmp1_d   = tmp1_q;
        reg_id_d = reg_id_q;
        reg_re_d = reg_re_q;
        reg_wd_d = reg_wd_q;
        reg_we_d = reg_we_q;
        fin_d    = fin_q;
        skip_d   = skip_q;
        if (busy && !enabled) begin
            // Abort: a write already pulsed has committed; nothing further is issued.
            reg_re_d = 1'b0;
            reg_we_d = 1'b0;
            fin_d    = 1'b0;
            skip_d   = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enabled) begin
                        mode_d = isa_mode_e'(mode);
                        r0_d   = r0;
                        r1_d   = r1;
                        if (isa_mode_e'(mode) == ISA_LDI) begin
                            reg_id_d = r1;
                            reg_wd_d = imm;
                            reg_we_d = 1'b1;
                            state_d  = ST_WR1;
                        end else begin
                            reg_id_d = r0;
                            reg_re_d = 1'b1;
                            state_d  = ST_RD0;
                        end
                    end
                end
                ST_RD0: begin
                    tmp0_d = reg_out;
                    if (mode_q == ISA_XCHG) begin
                        reg_id_d = r1_q;
                        state_d  = ST_RD1;
                    end else if (mode_q == ISA_MOVNZ && reg_out == '0) begin
                        reg_re_d = 1'b0;
                        fin_d    = 1'b1;
                        skip_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        reg_re_d = 1'b0;
                        reg_id_d = r1_q;
                        reg_wd_d = reg_out;
                        reg_we_d = 1'b1;
                        state_d  = ST_WR1;
                    end
                end
                ST_RD1: begin
                    tmp1_d   = reg_out;
                    reg_re_d = 1'b0;
                    reg_id_d = r1_q;
                    reg_wd_d = tmp0_q;
                    reg_we_d = 1'b1;
                    state_d  = ST_WR1;
                end
                ST_WR1: begin
                    if (mode_q == ISA_XCHG) begin
                        reg_id_d = r0_q;
                        reg_wd_d = tmp1_q;
                        reg_we_d = 1'b1;
                        state_d  = ST_WR0;
                    end else begin
                        reg_we_d = 1'b0;
                        fin_d    = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
                ST_WR0: begin
                    reg_we_d = 1'b0;
                    fin_d    = 1'b1;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (!enabled) begin
                        fin_d   = 1'b0;
                        skip_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign reg_id    = reg_id_q;
    assign reg_re    = reg_re_q;
    assign reg_wd    = reg_wd_q;
    assign reg_we    = reg_we_q;
    assign finished  = fin_q;
    assign skipped   = skip_q;
    assign state_dbg = state_q;

endmodule
